// File: rtl/sd_sample_player.sv
// Sample playback buffer: a small FIFO feeding a held 8-bit sample bus that advances once per
// TICK_DIV clocks. Primes to PRIME_LEVEL before playing and counts underruns.
module sd_sample_player #(
    parameter int unsigned TICK_DIV    = 96,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned PRIME_LEVEL = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [7:0]                    sample_out,
    output logic                          sample_strobe,
    output logic                          playing,
    output logic [15:0]                   underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(TICK_DIV);

    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [LvlW-1:0] LvlOne   = LvlW'(1);
    localparam logic [LvlW-1:0] LvlFull  = LvlW'(FIFO_DEPTH);
    localparam logic [LvlW-1:0] LvlPrime = LvlW'(PRIME_LEVEL);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StPrime, StPlay} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]      sample_q, sample_d;
    logic            strobe_q;
    logic [15:0]     underrun_q, underrun_d;
    logic            push, pop, tick, underrun;

    assign in_ready = rst_n & (level_q < LvlFull);
    assign push     = in_valid & in_ready & ~flush;
    assign tick     = (state_q == StPlay) & (tick_cnt_q == TickLast);
    // Disable and flush both pre-empt the tick: no pop and no underrun on that edge.
    assign pop      = tick & enable & ~flush & (level_q != '0);
    assign underrun = tick & enable & ~flush & (level_q == '0);

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else if (flush) begin
            state_d = StPrime;
        end else begin
            case (state_q)
                StIdle:  state_d = StPrime;
                StPrime: if (level_q >= LvlPrime) state_d = StPlay;
                StPlay:  if (underrun) state_d = StPrime;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        level_d    = level_q;
        tick_cnt_d = '0;
        sample_d   = pop ? mem_q[rd_ptr_q] : sample_q;
        underrun_d = underrun_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LvlOne;
            2'b01:   level_d = level_q - LvlOne;
            default: level_d = level_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        // Counter only runs while staying in PLAY, so every entry to PLAY starts from zero.
        if (state_q == StPlay && state_d == StPlay) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + CntOne;
        end
        if (underrun && underrun_q != 16'hFFFF) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tick_cnt_q <= '0;
            sample_q   <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tick_cnt_q <= tick_cnt_d;
            sample_q   <= sample_d;
            strobe_q   <= pop;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign sample_out    = sample_q;
    assign sample_strobe = strobe_q;
    assign playing       = (state_q == StPlay);
    assign underrun_cnt  = underrun_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_sd_sample_player.sv
// Directed bench for sd_sample_player: reset, prime/play, underrun, backpressure, flush,
// disable, mid-play reset and underrun counter saturation.
module tb_sd_sample_player;

    logic        clk = 1'b0;
    logic        rst_n, enable, flush, in_valid, in_ready;
    logic [7:0]  in_data, sample_out;
    logic        sample_strobe, playing;
    logic [15:0] underrun_cnt;
    logic [2:0]  fifo_level;

    logic        s_rst_n, s_en, s_flush, s_valid, s_ready, s_strobe, s_playing;
    logic [7:0]  s_data, s_sample;
    logic [15:0] s_underrun;
    logic [2:0]  s_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sd_sample_player #(.TICK_DIV(4), .FIFO_DEPTH(4), .PRIME_LEVEL(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sample_out(sample_out), .sample_strobe(sample_strobe), .playing(playing),
        .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
    );

    sd_sample_player #(.TICK_DIV(2), .FIFO_DEPTH(4), .PRIME_LEVEL(1)) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .enable(s_en), .flush(s_flush),
        .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
        .sample_out(s_sample), .sample_strobe(s_strobe), .playing(s_playing),
        .underrun_cnt(s_underrun), .fifo_level(s_level)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 0; enable = 0; flush = 0; in_valid = 1; in_data = 8'h55;
        s_rst_n = 0; s_en = 0; s_flush = 0; s_valid = 0; s_data = 8'h00;

        // Reset held with a valid word presented
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", in_ready, 0);
            chk("rst_sample", sample_out, 0);
            chk("rst_strobe", sample_strobe, 0);
            chk("rst_level", fifo_level, 0);
            chk("rst_underrun", underrun_cnt, 0);
        end
        rst_n = 1; in_valid = 0;
        step();
        chk("post_rst_level", fifo_level, 0);
        chk("post_rst_ready", in_ready, 1);

        // Prime and play
        enable = 1; in_valid = 1; in_data = 8'h01;
        step();
        chk("prime_lvl1", fifo_level, 1);
        chk("prime_play1", playing, 0);
        in_data = 8'h02;
        step();
        chk("prime_lvl2", fifo_level, 2);
        chk("prime_play2", playing, 0);
        in_data = 8'h03;
        step();
        in_valid = 0;
        chk("play_rise", playing, 1);
        chk("play_lvl3", fifo_level, 3);

        // Strobes at +4, +8, +12; underrun at +16
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("play_strobe", sample_strobe, ((k % 4 == 0) && k <= 12) ? 1 : 0);
            chk("play_sample", sample_out, (k < 4) ? 0 : ((k >= 12) ? 3 : k / 4));
            if (k == 15) begin
                chk("pre_ur_playing", playing, 1);
                chk("pre_ur_cnt", underrun_cnt, 0);
            end
            if (k == 16) begin
                chk("ur_cnt", underrun_cnt, 1);
                chk("ur_playing", playing, 0);
            end
        end

        // Recovery
        in_valid = 1; in_data = 8'hAA;
        step();
        chk("rec_lvl1", fifo_level, 1);
        in_data = 8'hBB;
        step();
        chk("rec_play0", playing, 0);
        in_valid = 0;
        step();
        chk("rec_play1", playing, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("rec_strobe", sample_strobe, (k == 4) ? 1 : 0);
            chk("rec_sample", sample_out, (k == 4) ? 16'hAA : 16'h03);
        end
        chk("rec_lvl_after", fifo_level, 1);

        // Backpressure while disabled
        enable = 0; flush = 1;
        step();
        flush = 0;
        chk("bp_flush_lvl", fifo_level, 0);
        chk("bp_idle", playing, 0);
        chk("bp_hold", sample_out, 16'hAA);
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h10 + 8'(i);
            step();
        end
        chk("bp_full_lvl", fifo_level, 4);
        chk("bp_full_ready", in_ready, 0);
        in_data = 8'h14;
        step();
        step();
        chk("bp_hold_lvl", fifo_level, 4);
        chk("bp_hold_ready", in_ready, 0);
        enable = 1;
        step();
        chk("bp_prime", playing, 0);
        step();
        chk("bp_play", playing, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_nostrobe", sample_strobe, 0);
        end
        step();
        chk("bp_pop_strobe", sample_strobe, 1);
        chk("bp_pop_sample", sample_out, 16'h10);
        chk("bp_pop_lvl", fifo_level, 3);
        chk("bp_pop_ready", in_ready, 1);
        step();
        in_valid = 0;
        chk("bp_acc_lvl", fifo_level, 4);
        chk("bp_acc_ready", in_ready, 0);
        step();
        step();
        step();
        chk("fl_pre_strobe", sample_strobe, 1);
        chk("fl_pre_sample", sample_out, 16'h11);
        chk("fl_pre_lvl", fifo_level, 3);

        // Flush mid-play with a simultaneous push
        flush = 1; in_valid = 1; in_data = 8'h77;
        step();
        flush = 0; in_valid = 0;
        chk("fl_lvl", fifo_level, 0);
        chk("fl_playing", playing, 0);
        chk("fl_sample", sample_out, 16'h11);
        chk("fl_strobe", sample_strobe, 0);
        step();
        chk("fl_dropped", fifo_level, 0);

        // Disable with data arriving: no playback
        enable = 0; in_valid = 1;
        for (int k = 0; k < 11; k++) begin
            in_data = 8'h21 + 8'(k);
            if (k == 3) in_valid = 0;
            step();
            chk("dis_strobe", sample_strobe, 0);
            chk("dis_playing", playing, 0);
            chk("dis_sample", sample_out, 16'h11);
        end
        chk("dis_lvl", fifo_level, 3);

        // Reset during playback discards everything
        enable = 1;
        step();
        step();
        chk("mr_playing", playing, 1);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("mr_lvl", fifo_level, 0);
        chk("mr_sample", sample_out, 0);
        chk("mr_underrun", underrun_cnt, 0);
        chk("mr_playing0", playing, 0);

        // Underrun counter saturation: one word per 5-cycle prime/pop/underrun round
        step();
        s_rst_n = 1; s_en = 1;
        step();
        for (int n = 1; n <= 65537; n++) begin
            s_valid = 1; s_data = 8'(n);
            step();
            s_valid = 0;
            for (int j = 0; j < 4; j++) step();
            if (n == 2)     chk("sat_first", s_underrun, 16'h0001);
            if (n == 65535) chk("sat_fffe", s_underrun, 16'hFFFE);
            if (n == 65536) chk("sat_ffff", s_underrun, 16'hFFFF);
            if (n == 65537) chk("sat_hold", s_underrun, 16'hFFFF);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_sample_player.md
Name: sd_sample_player

Overview:
- Playback-side counterpart to the capture path. Buffers 8-bit samples arriving from upstream (SD reader / memory) in a small FIFO.
- Emits them as a held 8-bit sample bus updated once every TICK_DIV clocks, with a one-cycle strobe per new sample.
- Drives the `currentNum`-style sample bus consumed by the capture/LED debug logic and the audio output path.
- Primes before playing and counts underruns.

Parameters:
- TICK_DIV, 96: clocks per output sample period; legal range ≥2.
- FIFO_DEPTH, 16: FIFO entries; must be a power of two, ≥2.
- PRIME_LEVEL, 8: FIFO level required before playback starts or resumes; legal range 1..FIFO_DEPTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- enable  in  1  playback enable.
- flush  in  1  one-cycle pulse that empties the FIFO.
- in_data  in  8  upstream sample byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; transfer occurs when in_valid & in_ready.
- sample_out  out  8  current output sample, held between ticks.
- sample_strobe  out  1  high for exactly the one cycle in which sample_out takes a new value.
- playing  out  1  high while in PLAY.
- underrun_cnt  out  16  count of underrun events, saturating.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at a posedge):
  - FIFO empty, fifo_level=0, sample_out=0, sample_strobe=0, playing=0, underrun_cnt=0, tick counter=0, state=IDLE.
  - in_ready=0 while rst_n is low.
  - Reset mid-playback discards all FIFO contents.
- in_ready = rst_n & (fifo_level < FIFO_DEPTH). It is combinational from registered state only, with no path from in_valid.
- Push and pop in the same cycle: fifo_level unchanged. The pop returns the old head. A pushed word is never bypassed to the output in its push cycle.
- flush:
  - Read/write pointers and level go to 0 next cycle. An in_valid accepted in the same cycle is dropped; flush has priority.
  - In PLAY, PRIME or UNDERRUN with enable=1, state goes to PRIME. sample_out holds.
- Tick counter:
  - Runs only in PLAY. Cleared to 0 on every entry to PLAY.
  - Increments each cycle, wrapping from TICK_DIV-1 to 0. tick = (count==TICK_DIV-1).
- States:
  - IDLE: playing=0. Pushes are still accepted. enable=1 → PRIME.
  - PRIME: waits. fifo_level ≥ PRIME_LEVEL → PLAY on next edge.
  - PLAY, on a tick with fifo_level>0: pop, register the head into sample_out, assert sample_strobe on the same edge. The first strobe occurs TICK_DIV cycles after playing rises.
  - PLAY, on a tick with fifo_level==0: underrun. underrun_cnt += 1, saturating at 16'hFFFF. No strobe, sample_out holds, state → PRIME.
  - enable=0 in any state → IDLE next edge. FIFO retained, sample_out holds, tick counter cleared.
- At most one pop per TICK_DIV cycles. sample_strobe is never high on two consecutive cycles.
- Arithmetic:
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - fifo_level is one bit wider so full (== FIFO_DEPTH) is distinguishable from empty.
- Storage: registers or distributed RAM; no vendor primitives.

Test Plan (TICK_DIV=4, FIFO_DEPTH=4, PRIME_LEVEL=2):
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, in_data=8'h55 → in_ready=0, sample_out=0, sample_strobe=0, fifo_level=0, underrun_cnt=0 throughout; no write occurs.
- Prime and play: enable=1, push 01,02,03 back-to-back.
  - playing rises the cycle after fifo_level reaches 2.
  - Strobes occur 4, 8 and 12 cycles after playing rises, with sample_out=01,02,03.
  - sample_out is held between strobes.
- Underrun and recovery: continue from the previous test with no further pushes.
  - At the next tick: no strobe, underrun_cnt=1, playing=0, sample_out stays 03.
  - Push AA,BB → PLAY resumes; AA is emitted 4 cycles after playing rises.
- Backpressure: enable=0, present 5 words 10..14 continuously → in_ready drops after 4 accepts, fifo_level=4, 14 is held and not accepted. Set enable=1 → after the first pop, 14 is accepted.
- Flush and disable mid-play:
  - In PLAY with fifo_level=3, pulse flush together with an in_valid push → fifo_level=0 next cycle, the pushed word is dropped, state=PRIME, sample_out unchanged.
  - Then drop enable → playing=0; no strobe afterwards even with data present.
- Saturation: force 65,535 underruns (TICK_DIV=2, no data, repeated PRIME_LEVEL=1 refills of one word) → underrun_cnt stays 16'hFFFF after a further underrun.
